// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel divider, h/v counters, syncs, blank and strobes.
// Optional frame counter port enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int PIX_DIV = 2,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic        clk,
  input  logic        reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic        pix_tick,
  output logic        line_start,
`ifdef VGA_FRAME_CNT_EN
  output logic        frame_start,
  output logic [15:0] frame_cnt
`else
  output logic        frame_start
`endif
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DW    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DW-1:0] DIV_MAX = DW'(PIX_DIV - 1);

  localparam logic [9:0] H_MAX  = 10'(H_TOT - 1);
  localparam logic [9:0] V_MAX  = 10'(V_TOT - 1);
  localparam logic [9:0] H_VEND = 10'(H_VIS);
  localparam logic [9:0] V_VEND = 10'(V_VIS);
  localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC);

  logic [DW-1:0] div;
  logic [9:0]    hc;
  logic [9:0]    vc;
  logic [9:0]    hc_nx;
  logic [9:0]    vc_nx;
  logic          wrap_h;
  logic          wrap_v;

  assign wrap_h   = (hc == H_MAX);
  assign wrap_v   = (vc == V_MAX);
  assign pix_tick = ~reset & (div == DIV_MAX);

  always_comb begin
    hc_nx = hc;
    vc_nx = vc;
    if (pix_tick) begin
      hc_nx = wrap_h ? 10'd0 : hc + 10'd1;
      if (wrap_h)
        vc_nx = wrap_v ? 10'd0 : vc + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      div <= '0;
    else if (pix_tick)
      div <= '0;
    else
      div <= div + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else begin
      hc <= hc_nx;
      vc <= vc_nx;
    end
  end

  // Qualifiers follow the next position so they line up with DrawX/DrawY;
  // updating only on ticks keeps blank low at (0,0) right after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs    <= 1'b1;
      vs    <= 1'b1;
      blank <= 1'b0;
    end else if (pix_tick) begin
      hs    <= ~((hc_nx >= HS_BEG) && (hc_nx < HS_END));
      vs    <= ~((vc_nx >= VS_BEG) && (vc_nx < VS_END));
      blank <= (hc_nx < H_VEND) && (vc_nx < V_VEND);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_tick & wrap_h;
      frame_start <= pix_tick & wrap_h & wrap_v;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_q;

  always_ff @(posedge clk) begin
    if (reset)
      frame_q <= '0;
    else if (pix_tick & wrap_h & wrap_v)
      frame_q <= frame_q + 16'd1;
  end

  assign frame_cnt = frame_q;
`endif

  assign DrawX = hc;
  assign DrawY = vc;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized reset/run bench for vga_timing_gen against a
// pixel-count reference model, three parameter sets side by side.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  logic [9:0]  x0, y0, x1, y1, x2, y2;
  logic        hs0, vs0, bl0, pt0, ls0, fs0;
  logic        hs1, vs1, bl1, pt1, ls1, fs1;
  logic        hs2, vs2, bl2, pt2, ls2, fs2;
  logic [15:0] fc0, fc1, fc2;

`ifndef VGA_FRAME_CNT_EN
  assign fc0 = '0;
  assign fc1 = '0;
  assign fc2 = '0;
`endif

  vga_timing_gen u0 (
    .clk(clk), .reset(reset), .DrawX(x0), .DrawY(y0),
    .hs(hs0), .vs(vs0), .blank(bl0), .pix_tick(pt0),
    .line_start(ls0),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt(fc0),
`endif
    .frame_start(fs0)
  );

  vga_timing_gen #(
    .PIX_DIV(1), .H_VIS(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_VIS(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u1 (
    .clk(clk), .reset(reset), .DrawX(x1), .DrawY(y1),
    .hs(hs1), .vs(vs1), .blank(bl1), .pix_tick(pt1),
    .line_start(ls1),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt(fc1),
`endif
    .frame_start(fs1)
  );

  vga_timing_gen #(
    .PIX_DIV(3), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u2 (
    .clk(clk), .reset(reset), .DrawX(x2), .DrawY(y2),
    .hs(hs2), .vs(vs2), .blank(bl2), .pix_tick(pt2),
    .line_start(ls2),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt(fc2),
`endif
    .frame_start(fs2)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  // n = clock edges since the last reset edge; the pixel count and the
  // raster position follow directly from it.
  task automatic check_inst(
    input string nm, input int d,
    input int hv, input int hf, input int hsy, input int hb,
    input int vv, input int vf, input int vsy, input int vb,
    input logic [9:0] x, input logic [9:0] y,
    input logic h, input logic v, input logic bl,
    input logic pt, input logic ls, input logic fs,
    input logic [15:0] fc);
    int ht, vt, p, hc, vc, ph;
    bit e_hs, e_vs, e_bl, e_pt, e_ls, e_fs;
    ht = hv + hf + hsy + hb;
    vt = vv + vf + vsy + vb;
    p  = n / d;
    ph = n % d;
    hc = p % ht;
    vc = (p / ht) % vt;
    e_hs = !(hc >= hv + hf && hc < hv + hf + hsy);
    e_vs = !(vc >= vv + vf && vc < vv + vf + vsy);
    e_bl = (p != 0) && hc < hv && vc < vv;
    e_pt = !reset && (ph == d - 1);
    e_ls = (p != 0) && ph == 0 && hc == 0;
    e_fs = e_ls && vc == 0;
    check({nm, ".x"}, 32'(x), 32'(hc));
    check({nm, ".y"}, 32'(y), 32'(vc));
    check({nm, ".hs"}, 32'(h), 32'(e_hs));
    check({nm, ".vs"}, 32'(v), 32'(e_vs));
    check({nm, ".blank"}, 32'(bl), 32'(e_bl));
    check({nm, ".tick"}, 32'(pt), 32'(e_pt));
    check({nm, ".line"}, 32'(ls), 32'(e_ls));
    check({nm, ".frame"}, 32'(fs), 32'(e_fs));
`ifdef VGA_FRAME_CNT_EN
    check({nm, ".fcnt"}, 32'(fc), 32'((p / (ht * vt)) % 65536));
`else
    check({nm, ".fcnt"}, 32'(fc), 32'd0);
`endif
  endtask

  task automatic step(input bit r);
    reset = r;
    @(posedge clk);
    if (r) n = 0;
    else   n++;
    @(negedge clk);
    check_inst("u0", 2, 640, 16, 96, 48, 480, 10, 2, 33,
               x0, y0, hs0, vs0, bl0, pt0, ls0, fs0, fc0);
    check_inst("u1", 1, 16, 4, 6, 4, 10, 2, 2, 3,
               x1, y1, hs1, vs1, bl1, pt1, ls1, fs1, fc1);
    check_inst("u2", 3, 8, 2, 3, 3, 6, 1, 2, 2,
               x2, y2, hs2, vs2, bl2, pt2, ls2, fs2, fc2);
  endtask

  initial begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 3 * 1600 + 20; i++) step(1'b0);
    for (int k = 0; k < 12; k++) begin
      int run, hold;
      run  = int'($urandom_range(4000, 300));
      hold = int'($urandom_range(3, 1));
      for (int i = 0; i < run; i++) step(1'b0);
      for (int i = 0; i < hold; i++) step(1'b1);
    end
    for (int i = 0; i < 2000; i++) step(1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
